// File: rtl/prog_loader_pkg.sv
// Shared constants for the byte-stream program loader: command bytes and FSM state encoding.
package prog_loader_pkg;

    localparam logic [7:0] CMD_LOAD_I = 8'hA0;
    localparam logic [7:0] CMD_LOAD_D = 8'hA1;
    localparam logic [7:0] CMD_RUN    = 8'hB0;
    localparam logic [7:0] CMD_HALT   = 8'hC0;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADDR0 = 3'd1;
    localparam logic [STATE_W-1:0] ST_ADDR1 = 3'd2;
    localparam logic [STATE_W-1:0] ST_CNT0  = 3'd3;
    localparam logic [STATE_W-1:0] ST_CNT1  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DATA  = 3'd5;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd6;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: parses command frames from a valid/ready byte stream, writes words into
// instruction/data memory and owns the processor reset line.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              err
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         addr_lo_q, addr_lo_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               addr_bad_q, addr_bad_d;
    logic [31:0]        shift_q, shift_d;
    logic               rx_ready_q, rx_ready_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               accept;
    logic [15:0]        full_addr;

    assign accept    = rx_valid && rx_ready_q;
    assign full_addr = {rx_data, addr_lo_q};

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            addr_lo_q   <= 8'd0;
            addr_q      <= '0;
            addr_bad_q  <= 1'b0;
            shift_q     <= 32'd0;
            rx_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            addr_lo_q   <= addr_lo_d;
            addr_q      <= addr_d;
            addr_bad_q  <= addr_bad_d;
            shift_q     <= shift_d;
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Frame parser, word assembler and next-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        addr_lo_d   = addr_lo_q;
        addr_d      = addr_q;
        addr_bad_d  = addr_bad_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (rx_data)
                        CMD_LOAD_I, CMD_LOAD_D: begin
                            state_d   = ST_ADDR0;
                            cpu_rst_d = 1'b1;
                            mem_sel_d = (rx_data == CMD_LOAD_D);
                        end
                        CMD_RUN: cpu_rst_d = 1'b0;
                        CMD_HALT: begin
                            cpu_rst_d = 1'b1;
                            err_d     = 1'b0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_ADDR0: begin
                if (accept) begin
                    addr_lo_d = rx_data;
                    state_d   = ST_ADDR1;
                end
            end
            ST_ADDR1: begin
                if (accept) begin
                    addr_d     = full_addr[ADDR_W-1:0];
                    addr_bad_d = ((full_addr >> ADDR_W) != 16'd0);
                    if (addr_bad_d) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_CNT0;
                end
            end
            ST_CNT0: begin
                if (accept) begin
                    cnt_d   = {8'h00, rx_data};
                    state_d = ST_CNT1;
                end
            end
            ST_CNT1: begin
                if (accept) begin
                    cnt_d = {rx_data, cnt_q[7:0]};
                    idx_d = 2'd0;
                    // A bad address or empty count ends the frame without touching memory
                    if (addr_bad_q || (cnt_d == 16'd0)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    shift_d = {rx_data, shift_q[31:8]};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d     = ST_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = shift_d;
                    end
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rx_ready_d = (state_d != ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: command table, directed frames and randomized loads
// compared against a word-level memory model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          mem_we;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          err;

    prog_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int we_count  = 0;
    int exp_we    = 0;
    bit mon_en    = 1'b0;
    bit rnd_gaps  = 1'b0;

    logic [31:0] imem_obs [DEPTH];
    logic [31:0] dmem_obs [DEPTH];
    logic [31:0] imem_exp [DEPTH];
    logic [31:0] dmem_exp [DEPTH];
    logic [31:0] wbuf [64];

    typedef struct {
        logic [7:0] cmd;
        logic       exp_cpu_rst;
        logic       exp_err;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Observed memory image and the WRITE-cycle handshake rule
    always @(negedge clk) begin
        if (mon_en) begin
            check("rx_ready_vs_we", 32'(rx_ready), 32'(!mem_we));
            if (mem_we) begin
                we_count++;
                if (mem_sel) dmem_obs[mem_addr] = mem_wdata;
                else         imem_obs[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (rnd_gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: rx_ready stuck at 0, expected 1 (byte %02h)", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // One LOAD frame of n words from wbuf; expected writes follow (addr + i) mod 2^AW
    task automatic load(input bit sel, input logic [15:0] addr, input int n);
        int prev;
        logic [AW-1:0] a;
        prev = 0;
        send_byte(sel ? CMD_LOAD_D : CMD_LOAD_I);
        check("load_cpu_rst", 32'(cpu_rst), 32'd1);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        if (n == 0) check("cnt0_busy", 32'(busy), 32'd0);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) send_byte(8'(wbuf[i] >> (8 * b)));
            a = AW'((int'(addr) + i) % DEPTH);
            check("we_pulse", 32'(mem_we), 32'd1);
            check("we_addr", 32'(mem_addr), 32'(a));
            check("we_data", mem_wdata, wbuf[i]);
            check("we_sel", 32'(mem_sel), 32'(sel));
            if (!rnd_gaps && i > 0) check("word_period", 32'(cyc - prev), 32'd5);
            prev = cyc;
            if (sel) dmem_exp[a] = wbuf[i];
            else     imem_exp[a] = wbuf[i];
        end
        exp_we += n;
        if (n > 0) begin
            @(negedge clk);
            check("we_one_cycle", 32'(mem_we), 32'd0);
            check("busy_after_load", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism_i, mism_d, nw;
        logic [15:0] ra;
        bit rs;

        for (int i = 0; i < DEPTH; i++) begin
            imem_obs[i] = 32'd0; dmem_obs[i] = 32'd0;
            imem_exp[i] = 32'd0; dmem_exp[i] = 32'd0;
        end
        tbl[0] = '{8'h55, 1'b0, 1'b1};
        tbl[1] = '{8'hB0, 1'b0, 1'b1};
        tbl[2] = '{8'hC0, 1'b1, 1'b0};
        tbl[3] = '{8'hB0, 1'b0, 1'b0};
        tbl[4] = '{8'hA5, 1'b0, 1'b1};
        tbl[5] = '{8'hC0, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 1'b1, 1'b1};

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_sel", 32'(mem_sel), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Instruction load
        wbuf[0] = 32'h00500093; wbuf[1] = 32'h00300113; wbuf[2] = 32'h002081B3;
        load(1'b0, 16'h0000, 3);
        check("t1_cpu_rst", 32'(cpu_rst), 32'd1);

        // Data load then run
        wbuf[0] = 32'h0000000A;
        load(1'b1, 16'h0002, 1);
        send_byte(CMD_RUN);
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);

        // Single-byte commands in IDLE
        for (int i = 0; i < 7; i++) begin
            send_byte(tbl[i].cmd);
            check("tbl_cpu_rst", 32'(cpu_rst), 32'(tbl[i].exp_cpu_rst));
            check("tbl_err", 32'(err), 32'(tbl[i].exp_err));
            check("tbl_busy", 32'(busy), 32'd0);
        end

        // Valid frame with err still pending, then HALT clears it
        wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'h12345678;
        load(1'b1, 16'h0100, 2);
        check("err_held", 32'(err), 32'd1);
        send_byte(CMD_HALT);
        check("halt_clr_err", 32'(err), 32'd0);

        // Address wrap
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
        load(1'b0, 16'h03FF, 2);

        // Out-of-range start address
        send_byte(CMD_LOAD_I); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h02); send_byte(8'h00);
        check("badaddr_err", 32'(err), 32'd1);
        check("badaddr_busy", 32'(busy), 32'd0);
        check("badaddr_we", 32'(mem_we), 32'd0);
        send_byte(CMD_HALT);
        check("badaddr_clr", 32'(err), 32'd0);

        // Empty count
        load(1'b0, 16'h0005, 0);

        // Reset in the middle of a word
        send_byte(CMD_RUN);
        check("pre_rst_run", 32'(cpu_rst), 32'd0);
        send_byte(CMD_LOAD_I); send_byte(8'h20); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_ready", 32'(rx_ready), 32'd1);
        rst = 1'b0;

        // LOAD while running halts the CPU
        send_byte(CMD_RUN);
        check("run2_cpu_rst", 32'(cpu_rst), 32'd0);
        wbuf[0] = 32'h0BADF00D;
        load(1'b0, 16'h0010, 1);

        // Randomized loads with valid gaps
        rnd_gaps = 1'b1;
        for (int f = 0; f < 4; f++) begin
            nw = (f == 0) ? 16 : $urandom_range(1, 8);
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom_range(0, DEPTH - 1));
            for (int i = 0; i < nw; i++) wbuf[i] = $urandom;
            load(rs, ra, nw);
        end
        rnd_gaps = 1'b0;

        repeat (3) @(negedge clk);
        mism_i = 0;
        mism_d = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (imem_obs[i] !== imem_exp[i]) mism_i++;
            if (dmem_obs[i] !== dmem_exp[i]) mism_d++;
        end
        check("imem_image", 32'(mism_i), 32'd0);
        check("dmem_image", 32'(mism_d), 32'd0);
        check("dmem2", dmem_obs[2], 32'h0000000A);
        check("we_count", 32'(we_count), 32'(exp_we));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream boot loader for the single-cycle `riscv_processor`. It receives command frames over a valid/ready byte interface and assembles little-endian 32-bit words. It writes those words into the processor's instruction or data memory through a dedicated write port. It also owns the processor's reset line, so the CPU stays halted while a program is loaded and is released by an explicit run command. This replaces hierarchical backdoor preloading of `instr_mem`/`data_mem` with a synthesizable path.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width of each memory (1024 words).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  incoming byte.
- `rx_ready`  out  1  loader accepts a byte; transfer occurs when `rx_valid && rx_ready` at a rising edge.
- `mem_we`  out  1  one-cycle word write strobe.
- `mem_sel`  out  1  write target: 0 = instruction memory, 1 = data memory.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  word to write.
- `cpu_rst`  out  1  reset to `riscv_processor`, active-high.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `err`  out  1  sticky protocol error flag.

## Operation
Commands, first byte of each frame:
- `0xA0` LOAD_I, `0xA1` LOAD_D: followed by ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then 4·CNT data bytes, least significant byte first.
- `0xB0` RUN: clears `cpu_rst`.
- `0xC0` HALT: sets `cpu_rst` and clears `err`.
- Any other byte in IDLE: consumed, sets `err`, state stays IDLE.

Load behaviour:
- LOAD_x sets `cpu_rst` when the command byte is accepted, so a running CPU is halted before any write.
- The 16-bit start address must have bits [15:ADDR_W] equal to zero. Otherwise: set `err`, discard the count bytes and all data, return to IDLE after CNT_HI. `rx_ready` stays high throughout, so the sender never stalls.
- CNT = 0: return to IDLE after CNT_HI; no write occurs.
- After every 4th data byte, go to WRITE for one cycle. During WRITE: `mem_we` = 1, `rx_ready` = 0, address increments afterwards.
- Address wraps modulo 2^ADDR_W with no error.
- After the last word, return to IDLE.

States: IDLE → ADDR0 → ADDR1 → CNT0 → CNT1 → DATA (2-bit byte index) ↔ WRITE → IDLE.
- `mem_sel` is latched at the command byte and held until the next LOAD command.
- `mem_addr` and `mem_wdata` are don't-care when `mem_we` = 0. They are registered and hold their last value.

## Timing
Reset values:
- `cpu_rst` = 1 (CPU held until RUN).
- `rx_ready` = 1.
- `mem_we` = 0, `mem_sel` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- `busy` = 0, `err` = 0.
- State = IDLE.

Cycle-level behaviour:
- Byte accept edge k for the 4th byte of a word → `mem_we` high during cycle k+1 only, with `mem_addr`/`mem_wdata` valid in that same cycle. `rx_ready` is low in cycle k+1.
- Sustained throughput: 1 word per 5 cycles.
- RUN accepted at edge k → `cpu_rst` low from cycle k+1.
- LOAD/HALT accepted at edge k → `cpu_rst` high from cycle k+1.
- RUN/HALT received mid-frame are data bytes, not commands.
- `rst` mid-frame: the partial word is discarded with no write, and all outputs take their reset values on the next edge.
- `rx_valid` low stalls the frame indefinitely; there is no timeout.

## Structure
- `prog_loader_pkg`: command constants (`CMD_LOAD_I`, `CMD_LOAD_D`, `CMD_RUN`, `CMD_HALT`) and the state enum. The bench imports the same package.
- Single module, no sub-module. The word assembler is a 32-bit shift register inside the FSM block.
- Integration: `cpu_rst` drives `riscv_processor` reset. `mem_we`/`mem_sel`/`mem_addr`/`mem_wdata` feed a second write port on `instr_mem`/`data_mem`. That port is only used while `cpu_rst` = 1.

## Test plan
1. Load instructions: after reset, send A0 00 00 03 00 then words 00500093, 00300113, 002081B3 (LSB first). Expect three `mem_we` pulses, `mem_sel` = 0, addresses 0/1/2, each pulse exactly 1 cycle after the 4th byte; `cpu_rst` stays 1.
2. Load data, then run: send A1 02 00 01 00 0A 00 00 00, then B0. Expect write data_mem[2] = 0000000A; `cpu_rst` falls 1 cycle after B0. Then run the existing 9-instruction program and check x1 = 5, x2 = 3, x3 = 8, x4 = FFFFFFFE.
3. Boundary cases:
   - A0 FF 03 02 00 + 2 words: writes to addresses 3FF then 000 (wrap).
   - A0 00 04 ...: sets `err`, no `mem_we`, frame fully consumed.
   - CNT = 0: no writes, `busy` low after CNT_HI.
4. Error and recovery: a 0x55 byte in IDLE sets `err`. A following valid frame still loads correctly with `err` still 1. C0 clears `err`.
5. Reset and halt: assert `rst` after 2 data bytes of a word → no write; `cpu_rst` = 1, `busy` = 0 next cycle. Separately, send A0 while running (after B0) → `cpu_rst` rises 1 cycle after the command byte.
6. Backpressure: random `rx_valid` gaps during a 16-word load → identical memory contents. `rx_ready` is low exactly in WRITE cycles.
